// File: rtl/iir_pkg.sv
// Shared definitions for the multi-channel biquad engine: register indices,
// FSM state encoding and accumulator width derivation.
package iir_pkg;

    localparam logic [2:0] B0     = 3'd0;
    localparam logic [2:0] B1     = 3'd1;
    localparam logic [2:0] B2     = 3'd2;
    localparam logic [2:0] A1     = 3'd3;
    localparam logic [2:0] A2     = 3'd4;
    localparam logic [2:0] X1     = 3'd5;
    localparam logic [2:0] Y1     = 3'd6;
    localparam logic [2:0] SATCNT = 3'd7;

    localparam int unsigned NCOEF = 5;

    typedef enum logic [2:0] {StIdle, StMul, StAcc, StRnd, StOut} state_t;

    // Three guard bits cover the sum of five full-width products.
    function automatic int unsigned acc_width(int unsigned coef_w, int unsigned data_w);
        return coef_w + data_w + 3;
    endfunction

endpackage

// File: rtl/iir_round_sat.sv
// Combinational round-half-up, arithmetic shift and clamp of the accumulator
// down to the sample width; sat flags a clamped result.
module iir_round_sat #(
    parameter int unsigned ACC_W     = 51,
    parameter int unsigned FRAC_BITS = 30,
    parameter int unsigned DATA_W    = 16
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] y,
    output logic                     sat
);

    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(64'd1 << (FRAC_BITS - 1));
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'd1 << (DATA_W - 1)) - 64'd1);
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        rounded = acc + HALF;
        shifted = rounded >>> FRAC_BITS;
        y       = shifted[DATA_W-1:0];
        sat     = 1'b0;
        if (shifted > MAXV) begin
            y   = MAXV[DATA_W-1:0];
            sat = 1'b1;
        end else if (shifted < MINV) begin
            y   = MINV[DATA_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed multi-channel direct-form-I biquad with valid/ready streaming
// and a register port. Define IIR_SAT_COUNT_EN for per-channel saturation counters.
module iir_biquad_mc
    import iir_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned COEF_W      = 32,
    parameter int unsigned FRAC_BITS   = 30,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned MUL_LATENCY = 2,
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CW-1:0]     in_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     out_chan,
    input  logic              clear_state,
    input  logic              cfg_write,
    input  logic              cfg_read,
    input  logic [CW+2:0]     cfg_address,
    input  logic [31:0]       cfg_writedata,
    output logic [31:0]       cfg_readdata,
    output logic [15:0]       drop_count,
    output logic              busy
);

    localparam int unsigned ACC_W = acc_width(COEF_W, DATA_W);
    localparam int unsigned PW    = COEF_W + DATA_W;

    state_t state_q;
    logic [7:0] mcnt_q;

    logic signed [COEF_W-1:0] coef_q [CHANNELS][NCOEF];
    logic signed [DATA_W-1:0] x1_q [CHANNELS];
    logic signed [DATA_W-1:0] x2_q [CHANNELS];
    logic signed [DATA_W-1:0] y1_q [CHANNELS];
    logic signed [DATA_W-1:0] y2_q [CHANNELS];

    // Snapshot of the accepted sample's channel context.
    logic signed [COEF_W-1:0] lc_q [NCOEF];
    logic signed [DATA_W-1:0] lx_q, lx1_q, lx2_q, ly1_q, ly2_q;
    logic [CW-1:0]            lch_q;
    logic                     clr_pend_q;

    logic signed [DATA_W-1:0] opd [NCOEF];
    logic signed [PW-1:0]     prod_q [MUL_LATENCY][NCOEF];
    logic signed [ACC_W-1:0]  acc_d, acc_q;
    logic signed [DATA_W-1:0] y_rs;
    logic                     sat;

    logic [DATA_W-1:0] out_data_q;
    logic [CW-1:0]     out_chan_q;
    logic              out_valid_q;
    logic [31:0]       rd_d, rd_q;
    logic [15:0]       drop_q;

    logic [CW-1:0] cfg_chan;
    logic [2:0]    cfg_idx;
    logic          chan_ok, cfg_ok;

`ifdef IIR_SAT_COUNT_EN
    logic [15:0] satcnt_q [CHANNELS];
`else
    logic unused_sat;
    assign unused_sat = sat;
`endif

    assign cfg_chan = cfg_address[CW+2:3];
    assign cfg_idx  = cfg_address[2:0];
    assign chan_ok  = {1'b0, in_chan} < (CW+1)'(CHANNELS);
    assign cfg_ok   = {1'b0, cfg_chan} < (CW+1)'(CHANNELS);

    assign in_ready     = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_chan     = out_chan_q;
    assign cfg_readdata = rd_q;
    assign drop_count   = drop_q;

    always_comb begin
        opd[0] = lx_q;
        opd[1] = lx1_q;
        opd[2] = lx2_q;
        opd[3] = ly1_q;
        opd[4] = ly2_q;
    end

    // Operands are held stable from the handshake, so the pipeline needs no enables.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCOEF; k++) begin
            prod_q[0][k] <= PW'(lc_q[k]) * PW'(opd[k]);
        end
        for (int s = 1; s < MUL_LATENCY; s++) begin
            prod_q[s] <= prod_q[s-1];
        end
    end

    always_comb begin
        acc_d = '0;
        for (int k = 0; k < 3; k++) acc_d += ACC_W'(prod_q[MUL_LATENCY-1][k]);
        for (int k = 3; k < NCOEF; k++) acc_d -= ACC_W'(prod_q[MUL_LATENCY-1][k]);
    end

    iir_round_sat #(
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS),
        .DATA_W    (DATA_W)
    ) u_round_sat (
        .acc (acc_q),
        .y   (y_rs),
        .sat (sat)
    );

    always_comb begin
        rd_d = '0;
        if (cfg_ok) begin
            unique case (cfg_idx)
                B0, B1, B2, A1, A2: rd_d = 32'(coef_q[cfg_chan][cfg_idx]);
                X1:                 rd_d = 32'(x1_q[cfg_chan]);
                Y1:                 rd_d = 32'(y1_q[cfg_chan]);
`ifdef IIR_SAT_COUNT_EN
                SATCNT:             rd_d = {16'd0, satcnt_q[cfg_chan]};
`else
                SATCNT:             rd_d = '0;
`endif
                default:            rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rd_q        <= '0;
            drop_q      <= '0;
            clr_pend_q  <= 1'b0;
            acc_q       <= '0;
            lch_q       <= '0;
            lx_q        <= '0;
            lx1_q       <= '0;
            lx2_q       <= '0;
            ly1_q       <= '0;
            ly2_q       <= '0;
            for (int k = 0; k < NCOEF; k++) lc_q[k] <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < NCOEF; k++) coef_q[c][k] <= '0;
                coef_q[c][0] <= COEF_W'(64'd1 << FRAC_BITS);
                x1_q[c] <= '0;
                x2_q[c] <= '0;
                y1_q[c] <= '0;
                y2_q[c] <= '0;
`ifdef IIR_SAT_COUNT_EN
                satcnt_q[c] <= '0;
`endif
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && chan_ok) begin
                        lx_q    <= in_data;
                        lch_q   <= in_chan;
                        lx1_q   <= x1_q[in_chan];
                        lx2_q   <= x2_q[in_chan];
                        ly1_q   <= y1_q[in_chan];
                        ly2_q   <= y2_q[in_chan];
                        lc_q    <= coef_q[in_chan];
                        mcnt_q  <= '0;
                        state_q <= StMul;
                    end else if (in_valid && drop_q != 16'hFFFF) begin
                        drop_q <= drop_q + 16'd1;
                    end
                end
                StMul: begin
                    mcnt_q <= mcnt_q + 8'd1;
                    if (mcnt_q == 8'(MUL_LATENCY)) state_q <= StAcc;
                end
                StAcc: begin
                    acc_q   <= acc_d;
                    state_q <= StRnd;
                end
                StRnd: begin
                    out_data_q  <= y_rs;
                    out_chan_q  <= lch_q;
                    out_valid_q <= 1'b1;
                    if (!clr_pend_q) begin
                        x2_q[lch_q] <= lx1_q;
                        x1_q[lch_q] <= lx_q;
                        y2_q[lch_q] <= ly1_q;
                        y1_q[lch_q] <= y_rs;
                    end
`ifdef IIR_SAT_COUNT_EN
                    if (sat && satcnt_q[lch_q] != 16'hFFFF) begin
                        satcnt_q[lch_q] <= satcnt_q[lch_q] + 16'd1;
                    end
`endif
                    state_q <= StOut;
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // A clear seen after the snapshot marks that sample's writeback as stale.
            clr_pend_q <= clear_state | (clr_pend_q & ~(state_q == StIdle && in_valid));
            if (clear_state) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    x1_q[c] <= '0;
                    x2_q[c] <= '0;
                    y1_q[c] <= '0;
                    y2_q[c] <= '0;
                end
            end

            if (cfg_write && cfg_ok) begin
                if (cfg_idx < 3'(NCOEF)) coef_q[cfg_chan][cfg_idx] <= cfg_writedata[COEF_W-1:0];
`ifdef IIR_SAT_COUNT_EN
                if (cfg_idx == SATCNT) satcnt_q[cfg_chan] <= '0;
`endif
            end
            if (cfg_read) rd_q <= rd_d;
        end
    end

endmodule
